fp_to_int: RTL and testbench

- Converts a bfloat16 operand (1 sign, 8 exponent, 7 mantissa bits, bias 127) to a 32-bit signed or unsigned integer.
- This is the inverse of the FPU int-to-bf16 converter.
- 3-stage pipeline with valid/ready handshakes on both sides; sits in the FPU datapath between the operand register and the integer writeback mux.
- Rounding is round-to-nearest-even; out-of-range results saturate.

---
 rtl/fp_to_int.sv | 221 ++++++++++++++++++++++
 tb/tb_fp_to_int.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_to_int.sv
// bfloat16 -> int32/uint32 converter (round-to-nearest-even, saturating).
// Latency 3 cycles (decode, align, round/saturate), throughput 1 per cycle.
// Backpressure: one global stall (out_valid_o & ~out_ready_i) freezes every stage; in_ready_o = ~stall.
// Optional macro FP_TO_INT_FLAGS_EN adds the registered invalid_o / inexact_o outputs.
module fp_to_int #(
  parameter logic ZERO_ON_NAN = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [15:0] fp_i,
  input  logic        mode_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] int_o
`ifdef FP_TO_INT_FLAGS_EN
  ,
  output logic        invalid_o,
  output logic        inexact_o
`endif
);

  typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_e;

  logic stall;
  logic adv;
  assign stall      = out_valid_o & ~out_ready_i;
  assign adv        = ~stall;
  assign in_ready_o = adv;

  // ---------------- S1: decode ----------------
  logic        [7:0] exp_w;
  logic signed [8:0] s1_e_d;
  cls_e              s1_cls_d;

  logic              s1_vld_q, s1_sign_q, s1_mode_q;
  logic signed [8:0] s1_e_q;
  logic        [6:0] s1_mant_q;
  cls_e              s1_cls_q;

  assign exp_w  = fp_i[14:7];
  assign s1_e_d = $signed({1'b0, exp_w}) - 9'sd127;

  // Classify the operand; denormals are flushed to zero.
  always_comb begin
    s1_cls_d = CLS_NORM;
    if (exp_w == 8'd0)        s1_cls_d = CLS_ZERO;
    else if (exp_w == 8'hFF)  s1_cls_d = (fp_i[6:0] == 7'd0) ? CLS_INF : CLS_NAN;
  end

  // Stage 1 register: captures the operand on accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q <= 1'b0;
    end else if (adv) begin
      s1_vld_q <= in_valid_i;
      if (in_valid_i) begin
        s1_sign_q <= fp_i[15];
        s1_mode_q <= mode_i;
        s1_e_q    <= s1_e_d;
        s1_mant_q <= fp_i[6:0];
        s1_cls_q  <= s1_cls_d;
      end
    end
  end

  // ---------------- S2: align ----------------
  logic [7:0]  sig;
  logic [15:0] rsh;
  logic [31:0] s2_mag_d;
  logic        s2_g_d, s2_s_d;

  logic              s2_vld_q, s2_sign_q, s2_mode_q, s2_mant_nz_q, s2_g_q, s2_s_q;
  logic signed [8:0] s2_e_q;
  logic       [31:0] s2_mag_q;
  cls_e              s2_cls_q;

  assign sig = {1'b1, s1_mant_q};

  // Place the significand in the integer field and collect guard/sticky bits.
  always_comb begin
    s2_mag_d = '0;
    s2_g_d   = 1'b0;
    s2_s_d   = 1'b0;
    rsh      = '0;
    if (s1_cls_q == CLS_NORM) begin
      if (s1_e_q > 9'sd31) begin
        s2_mag_d = '1;  // out of range; S3 saturates, value only needs to be nonzero
      end else if (s1_e_q >= 9'sd7) begin
        s2_mag_d = {24'd0, sig} << (s1_e_q[4:0] - 5'd7);
      end else if (s1_e_q >= 9'sd0) begin
        rsh      = {sig, 8'd0} >> (3'd7 - s1_e_q[2:0]);
        s2_mag_d = {24'd0, rsh[15:8]};
        s2_g_d   = rsh[7];
        s2_s_d   = |rsh[6:0];
      end else if (s1_e_q == -9'sd1) begin
        s2_g_d = 1'b1;
        s2_s_d = |s1_mant_q;
      end else begin
        s2_s_d = 1'b1;
      end
    end
  end

  // Stage 2 register: aligned magnitude plus the context S3 needs to saturate.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_vld_q <= 1'b0;
    end else if (adv) begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_sign_q    <= s1_sign_q;
        s2_mode_q    <= s1_mode_q;
        s2_e_q       <= s1_e_q;
        s2_mant_nz_q <= |s1_mant_q;
        s2_cls_q     <= s1_cls_q;
        s2_mag_q     <= s2_mag_d;
        s2_g_q       <= s2_g_d;
        s2_s_q       <= s2_s_d;
      end
    end
  end

  // ---------------- S3: round / saturate ----------------
  logic        inc;
  logic [31:0] mag_r;
  logic [31:0] s3_int_d;
  logic        s3_inv_d, s3_inx_d;

  logic        s3_vld_q;
  logic [31:0] s3_int_q;

  // RNE only fires when the magnitude is below 256, so the add never wraps.
  assign inc   = s2_g_q & (s2_s_q | s2_mag_q[0]);
  assign mag_r = s2_mag_q + {31'd0, inc};

  // Select the rounded value or the saturation constant and derive the flags.
  always_comb begin
    s3_int_d = '0;
    s3_inv_d = 1'b0;
    unique case (s2_cls_q)
      CLS_ZERO: s3_int_d = '0;
      CLS_NAN: begin
        s3_inv_d = 1'b1;
        if (!ZERO_ON_NAN) s3_int_d = s2_mode_q ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
      end
      CLS_INF: begin
        s3_inv_d = 1'b1;
        if (s2_mode_q) s3_int_d = s2_sign_q ? 32'h0000_0000 : 32'hFFFF_FFFF;
        else           s3_int_d = s2_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      default: begin
        if (!s2_mode_q) begin
          if (!s2_sign_q) begin
            if (s2_e_q >= 9'sd31) begin
              s3_int_d = 32'h7FFF_FFFF;
              s3_inv_d = 1'b1;
            end else begin
              s3_int_d = mag_r;
            end
          end else if (s2_e_q > 9'sd31 || (s2_e_q == 9'sd31 && s2_mant_nz_q)) begin
            s3_int_d = 32'h8000_0000;
            s3_inv_d = 1'b1;
          end else begin
            s3_int_d = -mag_r;  // -2^31 exactly negates to itself
          end
        end else begin
          if (!s2_sign_q) begin
            if (s2_e_q >= 9'sd32) begin
              s3_int_d = 32'hFFFF_FFFF;
              s3_inv_d = 1'b1;
            end else begin
              s3_int_d = mag_r;
            end
          end else begin
            s3_int_d = '0;
            s3_inv_d = (s2_e_q >= 9'sd32) || (mag_r != 32'd0);
          end
        end
      end
    endcase
    s3_inx_d = (s2_g_q | s2_s_q) & ~s3_inv_d;
  end

  // Output register: holds its value while stalled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s3_vld_q <= 1'b0;
      s3_int_q <= '0;
    end else if (adv) begin
      s3_vld_q <= s2_vld_q;
      if (s2_vld_q) s3_int_q <= s3_int_d;
    end
  end

  assign out_valid_o = s3_vld_q;
  assign int_o       = s3_int_q;

`ifdef FP_TO_INT_FLAGS_EN
  logic s3_inv_q, s3_inx_q;

  // Flag register travels alongside the integer result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s3_inv_q <= 1'b0;
      s3_inx_q <= 1'b0;
    end else if (adv && s2_vld_q) begin
      s3_inv_q <= s3_inv_d;
      s3_inx_q <= s3_inx_d;
    end
  end

  assign invalid_o = s3_inv_q;
  assign inexact_o = s3_inx_q;
`else
  logic unused_flags;
  assign unused_flags = s3_inv_d ^ s3_inx_d;
`endif

endmodule

// File: tb/tb_fp_to_int.sv
module tb_fp_to_int;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] fp;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
`ifdef FP_TO_INT_FLAGS_EN
  logic        invalid, inexact;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp_to_int #(.ZERO_ON_NAN(1'b0)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .fp_i        (fp),
    .mode_i      (mode),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .int_o       (int_out)
`ifdef FP_TO_INT_FLAGS_EN
    ,
    .invalid_o   (invalid),
    .inexact_o   (inexact)
`endif
  );

  typedef struct {
    logic [15:0] fp;
    logic        mode;
    logic [31:0] exp_int;
    logic        exp_inv;
    logic        exp_inx;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    bit got;
    @(negedge clk);
    in_valid  = 1'b1;
    fp        = v.fp;
    mode      = v.mode;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    for (int t = 0; t < 8 && !got; t++) begin
      if (out_valid) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      check($sformatf("vec%0d_timeout", idx), 32'd0, 32'd1);
    end else begin
      check($sformatf("vec%0d_int", idx), int_out, v.exp_int);
`ifdef FP_TO_INT_FLAGS_EN
      check($sformatf("vec%0d_inv", idx), {31'd0, invalid}, {31'd0, v.exp_inv});
      check($sformatf("vec%0d_inx", idx), {31'd0, inexact}, {31'd0, v.exp_inx});
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bp_fp  [4];
    logic [31:0] bp_exp [4];
    logic [31:0] held;
    bit          have_held;
    int          in_idx, out_idx, lat;

    //            fp        mode  expected        inv   inx
    vecs[0]  = '{16'h3FC0, 1'b0, 32'h0000_0002, 1'b0, 1'b1};  //  1.5 tie -> 2
    vecs[1]  = '{16'h4020, 1'b0, 32'h0000_0002, 1'b0, 1'b1};  //  2.5 tie -> 2
    vecs[2]  = '{16'hC2F7, 1'b0, 32'hFFFF_FF84, 1'b0, 1'b1};  // -123.5 -> -124
    vecs[3]  = '{16'h4F00, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0};  //  2^31 signed
    vecs[4]  = '{16'h4F00, 1'b1, 32'h8000_0000, 1'b0, 1'b0};  //  2^31 unsigned
    vecs[5]  = '{16'hCF00, 1'b0, 32'h8000_0000, 1'b0, 1'b0};  // -2^31 exact
    vecs[6]  = '{16'h7F80, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};  // +inf unsigned
    vecs[7]  = '{16'h7FC0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0};  // NaN signed
    vecs[8]  = '{16'hBE80, 1'b1, 32'h0000_0000, 1'b0, 1'b1};  // -0.25 unsigned
    vecs[9]  = '{16'hBF80, 1'b1, 32'h0000_0000, 1'b1, 1'b0};  // -1.0 unsigned
    vecs[10] = '{16'h0001, 1'b0, 32'h0000_0000, 1'b0, 1'b0};  // denormal
    vecs[11] = '{16'h3F00, 1'b0, 32'h0000_0000, 1'b0, 1'b1};  //  0.5 tie -> 0
    vecs[12] = '{16'h3F40, 1'b0, 32'h0000_0001, 1'b0, 1'b1};  //  0.75 -> 1
    vecs[13] = '{16'h3FE0, 1'b0, 32'h0000_0002, 1'b0, 1'b1};  //  1.75 -> 2
    vecs[14] = '{16'h4B80, 1'b0, 32'h0100_0000, 1'b0, 1'b0};  //  2^24
    vecs[15] = '{16'hFF80, 1'b0, 32'h8000_0000, 1'b1, 1'b0};  // -inf signed
    vecs[16] = '{16'hFF80, 1'b1, 32'h0000_0000, 1'b1, 1'b0};  // -inf unsigned
    vecs[17] = '{16'hC000, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};  // -2
    vecs[18] = '{16'h7FC1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};  // NaN unsigned
    vecs[19] = '{16'hCF01, 1'b0, 32'h8000_0000, 1'b1, 1'b0};  // below -2^31
    vecs[20] = '{16'h4F80, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};  //  2^32 unsigned
    vecs[21] = '{16'h40A0, 1'b0, 32'h0000_0005, 1'b0, 1'b0};  //  5.0

    bp_fp[0] = 16'h4080; bp_exp[0] = 32'd4;
    bp_fp[1] = 16'h40A0; bp_exp[1] = 32'd5;
    bp_fp[2] = 16'h40C0; bp_exp[2] = 32'd6;
    bp_fp[3] = 16'h40E0; bp_exp[3] = 32'd7;

    // Reset
    rst = 1'b1; in_valid = 1'b0; fp = '0; mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_int", int_out, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors
    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Back-to-back throughput: 1.0, 2.0, 3.0
    @(negedge clk);
    out_ready = 1'b1; mode = 1'b0;
    in_valid = 1'b1; fp = 16'h3F80;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("thru_valid_c%0d", k), {31'd0, out_valid}, (k >= 3 && k <= 5) ? 32'd1 : 32'd0);
      if (k >= 3 && k <= 5) check($sformatf("thru_int_c%0d", k), int_out, k - 2);
      if (k == 1)      fp = 16'h4000;
      else if (k == 2) fp = 16'h4040;
      else             in_valid = 1'b0;
    end

    // Backpressure: 4 inputs, output stalled for 5 cycles after first valid
    in_idx = 0; out_idx = 0; have_held = 1'b0; held = '0;
    for (int k = 0; k < 40 && out_idx < 4; k++) begin
      @(negedge clk);
      out_ready = !(k >= 3 && k <= 7);
      in_valid  = (in_idx < 4);
      fp        = bp_fp[in_idx < 4 ? in_idx : 3];
      #1;
      if (k == 3) check("bp_first_valid", {31'd0, out_valid}, 32'd1);
      if (out_valid) begin
        if (out_ready) begin
          check($sformatf("bp_out%0d", out_idx), int_out, bp_exp[out_idx]);
          out_idx++;
        end else begin
          check($sformatf("bp_in_ready_k%0d", k), {31'd0, in_ready}, 32'd0);
          if (have_held) check($sformatf("bp_hold_k%0d", k), int_out, held);
          held = int_out; have_held = 1'b1;
        end
      end
      if (in_valid && in_ready) in_idx++;
    end
    check("bp_delivered", out_idx, 32'd4);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("bp_no_dup%0d", k), {31'd0, out_valid}, 32'd0);
    end

    // Reset with three operations in flight
    out_ready = 1'b0;
    in_valid = 1'b1; fp = 16'h4080;
    @(negedge clk); fp = 16'h40A0;
    @(negedge clk); fp = 16'h40C0;
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("mid_rst_stale%0d", k), {31'd0, out_valid}, 32'd0);
    end
    in_valid = 1'b1; fp = 16'h4040; mode = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 6 && lat == 0; k++) begin
      if (out_valid) lat = k;
      else @(negedge clk);
    end
    check("mid_rst_latency", lat, 32'd3);
    check("mid_rst_int", int_out, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
